// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet filler.
//   state_t         : filler FSM states
//   WORD_W          : stream word width in bits
//   BYTES_PER_WORD  : bytes carried by one stream word
//   words_to_bytes  : converts a word count to a byte count
package pkt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        DONE
    } state_t;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic [31:0] words_to_bytes(input logic [31:0] words);
        return words * BYTES_PER_WORD;
    endfunction

endpackage

// File: rtl/packet_filler.sv
// Packet filler: takes a 32-bit stream packet and writes it to the dual-word
// packet RAM as 64-bit pairs (first word in the upper half, even address).
// Arms on buf_grant, reports length and truncation on the done/done_ack handshake.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   s_tdata/s_tvalid/s_tready/s_tlast   32-bit input stream
//   buf_grant                  a RAM buffer is free to fill (level)
//   wr_addr/wr_data/wr_en      RAM write port (pair address, pair data, strobe)
//   len_rst                    one-cycle pulse clearing the RAM length tracker
//   done/done_ack              packet complete / consumer took the buffer
//   byte_len, truncated        packet length in bytes, overflow flag (valid with done)
//
// state | meaning
// IDLE  | waiting for buf_grant, stream stalled
// FILL  | accepting beats, pairing words into RAM writes
// FLUSH | writing the final unpaired word padded with zero
// DONE  | length reported, waiting for done_ack
module packet_filler
    import pkt_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_W-1:0]     s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic                  buf_grant,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic                  len_rst,
    output logic                  done,
    input  logic                  done_ack,
    output logic [31:0]           byte_len,
    output logic                  truncated
);

    generate
        if (DATA_WIDTH != 2 * WORD_W) begin : g_bad_width
            $error("packet_filler: DATA_WIDTH must be twice the stream word width");
        end
    endgenerate

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] LAST_BASE = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [ADDR_WIDTH-1:0] BASE_STEP = {{(ADDR_WIDTH-2){1'b0}}, 2'b10};

    state_t                state;
    logic [WORD_W-1:0]     hold_reg;
    logic                  hold_full;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [ADDR_WIDTH-1:0] base;

    logic                  beat;
    logic                  room;
    logic [ADDR_WIDTH:0]   cnt_next;
    logic                  hold_after;

    // s_tready is a registered copy of "in FILL", so the beat term is safe to use here
    assign beat       = s_tvalid & s_tready;
    assign room       = (word_cnt < DEPTH_CNT);
    assign cnt_next   = room ? word_cnt + CNT_ONE : word_cnt;
    // Whether a word is left unpaired once the current beat is absorbed
    assign hold_after = room ? ~hold_full : hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            word_cnt  <= '0;
            base      <= '0;
            s_tready  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            len_rst   <= 1'b0;
            done      <= 1'b0;
            byte_len  <= '0;
            truncated <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            len_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (buf_grant) begin
                        len_rst   <= 1'b1;
                        word_cnt  <= '0;
                        base      <= '0;
                        hold_full <= 1'b0;
                        truncated <= 1'b0;
                        s_tready  <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (beat) begin
                        if (room) begin
                            if (!hold_full) begin
                                hold_reg  <= s_tdata;
                                hold_full <= 1'b1;
                            end else begin
                                wr_en     <= 1'b1;
                                wr_addr   <= base;
                                wr_data   <= {hold_reg, s_tdata};
                                hold_full <= 1'b0;
                                // base parks on the last pair instead of wrapping
                                if (base != LAST_BASE) begin
                                    base <= base + BASE_STEP;
                                end
                            end
                        end else begin
                            truncated <= 1'b1;
                        end
                        word_cnt <= cnt_next;
                        if (s_tlast) begin
                            s_tready <= 1'b0;
                            if (hold_after) begin
                                state <= FLUSH;
                            end else begin
                                done     <= 1'b1;
                                byte_len <= words_to_bytes(32'(cnt_next));
                                state    <= DONE;
                            end
                        end
                    end
                end
                FLUSH: begin
                    wr_en     <= 1'b1;
                    wr_addr   <= base;
                    wr_data   <= {hold_reg, {WORD_W{1'b0}}};
                    hold_full <= 1'b0;
                    done      <= 1'b1;
                    byte_len  <= words_to_bytes(32'(word_cnt));
                    state     <= DONE;
                end
                DONE: begin
                    if (done_ack) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_filler.sv
module tb_packet_filler;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic          buf_grant = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          wr_en;
    logic          len_rst;
    logic          done;
    logic          done_ack = 1'b0;
    logic [31:0]   byte_len;
    logic          truncated;

    packet_filler #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .buf_grant(buf_grant),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .len_rst(len_rst),
        .done(done), .done_ack(done_ack), .byte_len(byte_len), .truncated(truncated)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int          nbeats;
        logic [31:0] seed;
        int          gap_pct;
        int          exp_len;
        bit          exp_trunc;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every RAM write must match the next expected pair.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", wr_data, e.data);
            end
        end
    end

    function automatic logic [31:0] word_of(input logic [31:0] seed, input int i);
        return seed * 32'(i + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        int cyc = 0;
        buf_grant = 1'b1;
        tick();
        while (!s_tready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("arm_tready", 64'(s_tready), 64'd1);
        check("len_rst_pulse", 64'(len_rst), 64'd1);
        buf_grant = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] data, input logic last, input int gap_pct);
        int cyc = 0;
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            s_tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        s_tdata  = data;
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!s_tready && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!s_tready) begin
            check("beat_timeout", 64'(s_tready), 64'd1);
        end
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_packet(input int n, input logic [31:0] seed, input int gap_pct,
                              input int exp_len, input bit exp_trunc);
        int kept;
        int cyc = 0;
        kept = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < kept; i += 2) begin
            wr_t e;
            e.addr = AW'(i);
            e.data = (i + 1 < kept) ? {word_of(seed, i), word_of(seed, i + 1)}
                                    : {word_of(seed, i), 32'h0};
            exp_q.push_back(e);
        end
        arm();
        for (int i = 0; i < n; i++) begin
            send_beat(word_of(seed, i), (i == n - 1), gap_pct);
        end
        while (!done && cyc < 50) begin
            tick();
            cyc++;
        end
        check("done_set", 64'(done), 64'd1);
        check("byte_len", 64'(byte_len), 64'(exp_len));
        check("truncated", 64'(truncated), 64'(exp_trunc));
        check("tready_in_done", 64'(s_tready), 64'd0);
        @(negedge clk);
        #1;
        check("writes_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick();
        check("done_held", 64'(done), 64'd1);
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        check("done_cleared", 64'(done), 64'd0);
        check("idle_tready", 64'(s_tready), 64'd0);
    endtask

    initial begin
        vecs[0] = '{nbeats: 4,  seed: 32'h11111111, gap_pct: 0,  exp_len: 16, exp_trunc: 1'b0};
        vecs[1] = '{nbeats: 3,  seed: 32'hA0A0A0A0, gap_pct: 0,  exp_len: 12, exp_trunc: 1'b0};
        vecs[2] = '{nbeats: 1,  seed: 32'hDEADBEEF, gap_pct: 0,  exp_len: 4,  exp_trunc: 1'b0};
        vecs[3] = '{nbeats: 20, seed: 32'h01020304, gap_pct: 0,  exp_len: 64, exp_trunc: 1'b1};
        vecs[4] = '{nbeats: 6,  seed: 32'h13572468, gap_pct: 60, exp_len: 24, exp_trunc: 1'b0};

        #12;
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_byte_len", 64'(byte_len), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // done_ack while idle must not disturb anything
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        check("ack_in_idle_done", 64'(done), 64'd0);
        check("ack_in_idle_tready", 64'(s_tready), 64'd0);

        for (int v = 0; v < 5; v++) begin
            run_packet(vecs[v].nbeats, vecs[v].seed, vecs[v].gap_pct,
                       vecs[v].exp_len, vecs[v].exp_trunc);
            tick();
        end

        // Same 6-beat packet without gaps gives the identical write sequence
        run_packet(6, 32'h13572468, 0, 24, 1'b0);
        tick();

        // Reset two beats into a packet: pending write is dropped
        arm();
        send_beat(32'hCAFE0001, 1'b0, 0);
        s_tdata  = 32'hCAFE0002;
        s_tvalid = 1'b1;
        @(posedge clk);
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check("midrst_wr_en", 64'(wr_en), 64'd0);
        check("midrst_wr_addr", 64'(wr_addr), 64'd0);
        check("midrst_wr_data", wr_data, 64'd0);
        check("midrst_tready", 64'(s_tready), 64'd0);
        check("midrst_len_rst", 64'(len_rst), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_trunc", 64'(truncated), 64'd0);
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 64'(s_tready), 64'd0);
        run_packet(5, 32'h0BADF00D, 0, 20, 1'b0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
